// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared types and per-pass constants for the 8x8 sequential multiplier.
// Each pass selects one nibble of each operand and applies a fixed shift.
package mul8_seq_ctrl_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned PP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned PASS_W = 2;
  localparam int unsigned SHF_W  = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    P3   = 3'd4,
    DONE = 3'd5
  } state_t;

  // Bit k selects the nibble used in pass k (0 = low nibble, 1 = high nibble).
  localparam logic [3:0] A_SEL = 4'b1010;
  localparam logic [3:0] B_SEL = 4'b1100;

  function automatic logic [SHF_W-1:0] pass_shift(input logic [PASS_W-1:0] pass);
    case (pass)
      2'd0:    pass_shift = SHF_W'(0);
      2'd3:    pass_shift = SHF_W'(8);
      default: pass_shift = SHF_W'(4);
    endcase
  endfunction

  function automatic logic [PASS_W-1:0] pass_of(input state_t s);
    case (s)
      P1:      pass_of = PASS_W'(1);
      P2:      pass_of = PASS_W'(2);
      P3:      pass_of = PASS_W'(3);
      default: pass_of = PASS_W'(0);
    endcase
  endfunction

endpackage

// File: rtl/mul8_seq_ctrl_core.sv
// Combinational 4x4 unsigned array multiplier built from rows of ripple full adders.
module mult4x4_core
  import mul8_seq_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] m,
  input  logic [NIB_W-1:0] q,
  output logic [PP_W-1:0]  p
);

  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    fa = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Row 0 seeds the running sum; each later row adds the next partial product
  // to the upper bits of that sum and retires one product bit.
  function automatic logic [PP_W-1:0] array_mul(input logic [NIB_W-1:0] mm,
                                                input logic [NIB_W-1:0] qq);
    logic [NIB_W-1:0] row;
    logic [NIB_W-1:0] nrow;
    logic [1:0]       cs;
    logic             c;
    logic [PP_W-1:0]  res;
    res    = '0;
    res[0] = mm[0] & qq[0];
    row    = {1'b0, mm[3:1] & {3{qq[0]}}};
    for (int i = 1; i < NIB_W; i++) begin
      c    = 1'b0;
      nrow = '0;
      for (int j = 0; j < NIB_W; j++) begin
        cs      = fa(row[j], mm[j] & qq[i], c);
        nrow[j] = cs[0];
        c       = cs[1];
      end
      res[i] = nrow[0];
      row    = {c, nrow[3:1]};
    end
    res[7:4] = row;
    return res;
  endfunction

  assign p = array_mul(m, q);

endmodule

// File: rtl/mul8_seq_ctrl.sv
// 8x8 -> 16 unsigned multiply sequenced over four passes of one shared 4x4 core,
// with valid/ready handshakes on both operand and product sides.
module mul8_seq_ctrl
  import mul8_seq_ctrl_pkg::*;
#(
  parameter bit          SKIP_ZERO = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_count
);

  state_t              state;
  state_t              state_nxt;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   acc_nxt;
  logic [PROD_W-1:0]   addend;
  logic                capture;
  logic [PASS_W-1:0]   pass;
  logic [NIB_W-1:0]    core_m;
  logic [NIB_W-1:0]    core_q;
  logic [PP_W-1:0]     core_p;

  // Nibble mux into the single shared core, steered by the current pass.
  always_comb begin
    pass   = pass_of(state);
    core_m = A_SEL[pass] ? a_q[7:4] : a_q[3:0];
    core_q = B_SEL[pass] ? b_q[7:4] : b_q[3:0];
    addend = PROD_W'(core_p) << pass_shift(pass);
  end

  mult4x4_core u_core (
    .m (core_m),
    .q (core_q),
    .p (core_p)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          if (SKIP_ZERO && ((a == '0) || (b == '0))) begin
            acc_nxt   = '0;
            state_nxt = DONE;
          end else begin
            state_nxt = P0;
          end
        end
      end
      P0: begin
        acc_nxt   = addend;
        state_nxt = P1;
      end
      P1: begin
        acc_nxt   = acc + addend;
        state_nxt = P2;
      end
      P2: begin
        acc_nxt   = acc + addend;
        state_nxt = P3;
      end
      P3: begin
        acc_nxt   = acc + addend;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      product   <= '0;
      ops_count <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (capture) begin
        a_q <= a;
        b_q <= b;
      end
      acc       <= acc_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      busy      <= (state_nxt != IDLE);
      if ((state_nxt == DONE) && (state != DONE)) product <= acc_nxt;
      if (out_valid && out_ready) ops_count <= ops_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed and random checks of mul8_seq_ctrl with both SKIP_ZERO settings.
module tb_mul8_seq_ctrl;

  localparam int LAT_MAX = 20;
  localparam int NV      = 8;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  a, b;
  logic        in_ready, out_valid, busy;
  logic [15:0] product;
  logic [7:0]  ops_count;

  logic        in_valid2, out_ready2;
  logic [7:0]  a2, b2;
  logic        in_ready2, out_valid2, busy2;
  logic [15:0] product2;
  logic [7:0]  ops_count2;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  exp_ops;
  vec_t        vt[NV];

  always #5 clk = ~clk;

  mul8_seq_ctrl #(.SKIP_ZERO(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy), .ops_count(ops_count)
  );

  mul8_seq_ctrl #(.SKIP_ZERO(1'b0), .CNT_W(8)) dut_ns (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2),
    .product(product2), .busy(busy2), .ops_count(ops_count2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One transaction on the main instance with out_ready held high.
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi,
                        output logic [15:0] prod, output int lat);
    @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = ai; b = bi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = product;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] prod;
    logic [7:0]  ra, rb;
    int          lat;

    vt[0] = '{8'h12, 8'h34, 16'h03A8, 5};
    vt[1] = '{8'hFF, 8'hFF, 16'hFE01, 5};
    vt[2] = '{8'h80, 8'h02, 16'h0100, 5};
    vt[3] = '{8'hA5, 8'h00, 16'h0000, 1};
    vt[4] = '{8'h00, 8'h37, 16'h0000, 1};
    vt[5] = '{8'h01, 8'h01, 16'h0001, 5};
    vt[6] = '{8'hF0, 8'h0F, 16'h0E10, 5};
    vt[7] = '{8'h9C, 8'h4B, 16'h2DB4, 5};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
    exp_ops = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_ops_count", 32'(ops_count), 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].a, vt[i].b, prod, lat);
      exp_ops++;
      chk("tbl_product", 32'(prod), 32'(vt[i].prod));
      chk("tbl_latency", 32'(lat), 32'(vt[i].lat));
      chk("tbl_ops_count", 32'(ops_count), 32'(exp_ops));
      chk("tbl_in_ready_after", 32'(in_ready), 32'd1);
    end

    // Backpressure: result held for four cycles, operand pulses ignored.
    out_ready = 1'b0;
    @(negedge clk); a = 8'h0F; b = 8'hF0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1;
    while (!out_valid && lat < LAT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd5);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); a = 8'h11; b = 8'h22; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_product", 32'(product), 32'h0E10);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_ops_count", 32'(ops_count), 32'(exp_ops));
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    exp_ops++;
    chk("bp_ops_after", 32'(ops_count), 32'(exp_ops));
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp_ops_single", 32'(ops_count), 32'(exp_ops));
    chk("bp_idle", 32'(busy), 32'd0);

    // SKIP_ZERO=0 instance runs all four passes on a zero operand.
    @(negedge clk); a2 = 8'hA5; b2 = 8'h00; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0; lat = 1;
    while (!out_valid2 && lat < LAT_MAX) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("noskip_latency", 32'(lat), 32'd5);
    chk("noskip_product", 32'(product2), 32'd0);
    @(posedge clk); #1;
    chk("noskip_ops_count", 32'(ops_count2), 32'd1);

    // Reset during P2 drops the operation and clears everything.
    @(negedge clk); a = 8'h55; b = 8'h33; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_busy_before", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_ops_count", 32'(ops_count), 32'd0);
    @(negedge clk); rst = 1'b0; exp_ops = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_result", 32'(out_valid), 32'd0);
    run_op(8'h03, 8'h07, prod, lat);
    exp_ops++;
    chk("post_rst_product", 32'(prod), 32'h0015);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_ops", 32'(ops_count), 32'(exp_ops));

    // Random operands against a*b until the counter wraps.
    while (exp_ops != 8'hFF) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ra = '0;
      run_op(ra, rb, prod, lat);
      exp_ops++;
      chk("rnd_product", 32'(prod), 32'(16'(ra) * 16'(rb)));
      chk("rnd_latency", 32'(lat), ((ra == 8'h00) || (rb == 8'h00)) ? 32'd1 : 32'd5);
    end
    chk("wrap_pre_ff", 32'(ops_count), 32'h00FF);
    run_op(8'h0A, 8'h0B, prod, lat);
    chk("wrap_product", 32'(prod), 32'h006E);
    chk("wrap_to_zero", 32'(ops_count), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
